// File: rtl/lru_set_ctrl_pkg.sv
// Shared types and defaults for the per-set LRU rank controller.
package lru_set_ctrl_pkg;

  localparam int LRU_WIDTH    = 3;
  localparam int LRU_SET_BITS = 5;
  localparam int LRU_COUNT    = 1 << LRU_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // One set's ranks at default geometry; element w is the rank of way w.
  typedef logic [LRU_COUNT-1:0][LRU_WIDTH-1:0] rank_entry_t;

endpackage

// File: rtl/lru_single.sv
// Next-rank logic for one way: init value, promote to MRU, age by one, or hold.
module lru_single #(
  parameter int WIDTH   = 3,
  parameter int INITVAL = 0
) (
  input  logic [WIDTH-1:0] rank_i,
  input  logic [WIDTH-1:0] h_i,
  input  logic             touch_i,
  input  logic             init_i,
  output logic [WIDTH-1:0] rank_o
);

  always_comb begin
    rank_o = rank_i;
    if (init_i) begin
      rank_o = WIDTH'(INITVAL);
    end else if (touch_i) begin
      rank_o = '0;
    end else if (rank_i < h_i) begin
      rank_o = rank_i + 1'b1;
    end
  end

endmodule

// File: rtl/lru_set_ctrl.sv
// LRU rank store for NSETS sets of COUNT ways: init walk, one-cycle hit/miss update,
// permutation error detection with self-repair.
module lru_set_ctrl
  import lru_set_ctrl_pkg::*;
#(
  parameter int WIDTH    = LRU_WIDTH,
  parameter int SET_BITS = LRU_SET_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reinit,
  input  logic                req_en,
  input  logic [SET_BITS-1:0] req_set,
  input  logic                req_hit,
  input  logic [WIDTH-1:0]    req_way,
  output logic                busy,
  output logic                rsp_en,
  output logic [SET_BITS-1:0] rsp_set,
  output logic [WIDTH-1:0]    rsp_way,
  output logic                lru_err
);

  localparam int COUNT = 1 << WIDTH;
  localparam int NSETS = 1 << SET_BITS;
  localparam logic [WIDTH-1:0]    RANK_LRU = WIDTH'(COUNT - 1);
  localparam logic [SET_BITS-1:0] SET_LAST = SET_BITS'(NSETS - 1);

  typedef logic [COUNT-1:0][WIDTH-1:0] entry_t;

  state_e              state_q, state_d;
  logic [SET_BITS-1:0] walk_q, walk_d;
  logic                s1_vld_q, s1_vld_d;
  logic [SET_BITS-1:0] s1_set_q, s1_set_d;
  logic                s1_hit_q, s1_hit_d;
  logic [WIDTH-1:0]    s1_way_q, s1_way_d;

  entry_t              mem_q [NSETS];
  entry_t              cur;
  entry_t              upd;
  logic [WIDTH-1:0]    h;
  logic [WIDTH-1:0]    victim;
  logic [WIDTH-1:0]    touched;
  logic                found;
  logic                dup;
  logic                err;
  logic                in_init;
  logic                wr_en;
  logic [SET_BITS-1:0] wr_idx;

  always_comb begin
    state_d  = state_q;
    walk_d   = walk_q;
    s1_vld_d = 1'b0;
    s1_set_d = s1_set_q;
    s1_hit_d = s1_hit_q;
    s1_way_d = s1_way_q;
    if (reinit) begin
      state_d = ST_INIT;
      walk_d  = '0;
    end else if (state_q == ST_INIT) begin
      walk_d = walk_q + 1'b1;
      if (walk_q == SET_LAST) begin
        state_d = ST_IDLE;
      end
    end else if (req_en) begin
      s1_vld_d = 1'b1;
      s1_set_d = req_set;
      s1_hit_d = req_hit;
      s1_way_d = req_way;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      walk_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_set_q <= '0;
      s1_hit_q <= 1'b0;
      s1_way_q <= '0;
    end else begin
      state_q  <= state_d;
      walk_q   <= walk_d;
      s1_vld_q <= s1_vld_d;
      s1_set_q <= s1_set_d;
      s1_hit_q <= s1_hit_d;
      s1_way_q <= s1_way_d;
    end
  end

  // Descending scan so the lowest-numbered LRU way wins; no LRU way leaves victim at 0.
  always_comb begin
    cur    = mem_q[s1_set_q];
    found  = 1'b0;
    victim = '0;
    dup    = 1'b0;
    for (int w = COUNT - 1; w >= 0; w--) begin
      if (cur[w] == RANK_LRU) begin
        found  = 1'b1;
        victim = WIDTH'(w);
      end
    end
    for (int i = 0; i < COUNT; i++) begin
      for (int j = i + 1; j < COUNT; j++) begin
        if (cur[i] == cur[j]) dup = 1'b1;
      end
    end
    if (s1_hit_q) begin
      h       = cur[s1_way_q];
      touched = s1_way_q;
      err     = dup;
    end else begin
      h       = RANK_LRU;
      touched = victim;
      err     = !found;
    end
  end

  assign in_init = (state_q == ST_INIT);

  // The init walk reuses the updaters with init forced, so one write path serves both.
  for (genvar w = 0; w < COUNT; w++) begin : g_way
    lru_single #(
      .WIDTH  (WIDTH),
      .INITVAL(w)
    ) u_rank (
      .rank_i (cur[w]),
      .h_i    (h),
      .touch_i(touched == WIDTH'(w)),
      .init_i (err || in_init),
      .rank_o (upd[w])
    );
  end

  assign busy    = in_init;
  assign rsp_en  = s1_vld_q && !reinit;
  assign rsp_set = s1_set_q;
  assign rsp_way = s1_vld_q ? touched : '0;
  assign lru_err = rsp_en && err;
  assign wr_en   = in_init || rsp_en;
  assign wr_idx  = in_init ? walk_q : s1_set_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= upd;
    end
  end

endmodule
